// File: rtl/sm_debug_dumper.sv
// sm_debug_dumper: sweeps debug registers FIRST_REG..LAST_REG, emitting a 5-byte record per register (tag {3'b101,addr}, then data MSB first).
// Latency: start edge to first out_valid is 2 edges; 6 cycles per register with out_ready held high (one bubble cycle per register).
// Backpressure: out_data/out_valid hold while out_valid & !out_ready; start is ignored while busy.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle dump request, sampled only in IDLE
//   regAddr / regData    debug port address out, combinational register data in
//   out_data/out_valid/out_ready  byte stream with valid/ready handshake
//   busy, done           dump in progress; one-cycle pulse after the final byte is accepted
module sm_debug_dumper #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);
  localparam logic [2:0] LAST_BYTE  = 3'd4;

  typedef enum logic [1:0] {IDLE, ADDR, SEND} state_t;

  state_t      state, state_nx;
  logic [4:0]  addr_nx;
  logic [7:0]  data_nx;
  logic        valid_nx, busy_nx, done_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [39:0] shift, shift_nx;
  logic        accept;

  assign accept = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      regAddr   <= 5'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= 3'd0;
      shift     <= 40'd0;
    end else begin
      state     <= state_nx;
      regAddr   <= addr_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      cnt       <= cnt_nx;
      shift     <= shift_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = regAddr;
    data_nx  = out_data;
    valid_nx = out_valid;
    busy_nx  = busy;
    done_nx  = 1'b0;
    cnt_nx   = cnt;
    shift_nx = shift;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nx  = FIRST_ADDR;
          busy_nx  = 1'b1;
          state_nx = ADDR;
        end
      end
      // regAddr has been stable for a full cycle, so regData is settled here.
      ADDR: begin
        shift_nx = {3'b101, regAddr, regData};
        data_nx  = {3'b101, regAddr};
        valid_nx = 1'b1;
        cnt_nx   = 3'd0;
        state_nx = SEND;
      end
      SEND: begin
        if (accept) begin
          if (cnt != LAST_BYTE) begin
            // Rotate rather than shift so the tag byte stays in the register;
            // shift[31:24] is always the next data byte to present.
            data_nx  = shift[31:24];
            shift_nx = {shift[31:0], shift[39:32]};
            cnt_nx   = cnt + 3'd1;
          end else if (regAddr != LAST_ADDR) begin
            // Compare happens before the increment, so LAST_REG=31 never wraps.
            valid_nx = 1'b0;
            addr_nx  = regAddr + 5'd1;
            state_nx = ADDR;
          end else begin
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            addr_nx  = 5'd0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm_debug_dumper.sv
// Bench for sm_debug_dumper: a full-range instance (0..31) and a single-register
// instance (5..5) share one register-file model; expected bytes are queued at
// start and popped by per-instance monitors on each accepted byte.
module tb_sm_debug_dumper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done;

  logic        start5 = 1'b0;
  logic [4:0]  regAddr5;
  logic [31:0] regData5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic        out_ready5 = 1'b1;
  logic        busy5, done5;

  logic [31:0] regs [32];
  logic [7:0]  exp_q  [$];
  logic [7:0]  exp_q5 [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign regData  = regs[regAddr];
  assign regData5 = regs[regAddr5];

  sm_debug_dumper #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .regAddr(regAddr), .regData(regData),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  sm_debug_dumper #(.FIRST_REG(5), .LAST_REG(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .regAddr(regAddr5), .regData(regData5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .busy(busy5), .done(done5)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitors: a byte is accepted at the next rising edge when valid & ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
      else chk("stream_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid5 && out_ready5) begin
      if (exp_q5.size() == 0) chk("unexpected_byte5", {24'd0, out_data5}, 32'hFFFF_FFFF);
      else chk("stream_byte5", {24'd0, out_data5}, {24'd0, exp_q5.pop_front()});
    end
  end

  task automatic push_record(input int a);
    logic [4:0]  a5;
    logic [31:0] v;
    a5 = 5'(a);
    v  = regs[a];
    exp_q.push_back({3'b101, a5});
    exp_q.push_back(v[31:24]);
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endtask

  task automatic push_sweep();
    for (int a = 0; a < 32; a++) push_record(a);
  endtask

  // mode 0: ready high; 1: random ready; 2: 3-cycle stall on byte 34; 3: start held while busy.
  // exp_edge 0 means the done edge is not checked exactly.
  task automatic run_dump(input int mode, input int exp_edge);
    int edges, done_edge, done_cnt, stall;
    bit bp_done, stalled;
    push_sweep();
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    edges = 0; done_edge = 0; done_cnt = 0; stall = 0; bp_done = 0;
    while (edges < 3000 && !(done_edge != 0 && edges >= done_edge + 4)) begin
      @(posedge clk);
      edges++;
      #1;
      start = (mode == 3) ? busy : 1'b0;
      stalled = 1'b0;
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!bp_done && out_valid && out_data == 8'h34) begin
            stall = 3;
            bp_done = 1'b1;
          end
          if (stall > 0) begin
            out_ready = 1'b0;
            stalled = 1'b1;
            stall--;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_edge == 0) done_edge = edges;
      end
      if (done_edge == 0) chk("busy_during_dump", {31'd0, busy}, 32'd1);
      else chk("busy_after_done", {31'd0, busy}, 32'd0);
      if (stalled) begin
        chk("stall_data", {24'd0, out_data}, 32'h34);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    out_ready = 1'b1;
    start = 1'b0;
    if (done_edge == 0) chk("done_timeout", 32'd0, 32'd1);
    if (exp_edge != 0) chk("done_edge", done_edge, exp_edge);
    if (mode == 2) chk("stall_seen", {31'd0, bp_done}, 32'd1);
    chk("done_pulses", done_cnt, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic run_single();
    int edges;
    exp_q5.push_back(8'hA5);
    exp_q5.push_back(8'hDE);
    exp_q5.push_back(8'hAD);
    exp_q5.push_back(8'hBE);
    exp_q5.push_back(8'hEF);
    @(posedge clk); #1;
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    edges = 1;
    while (edges < 100) begin
      @(negedge clk);
      if (done5) break;
      @(posedge clk);
      edges++;
    end
    chk("single_done_edge", edges, 32'd7);
    chk("single_addr_back", {27'd0, regAddr5}, 32'd0);
    chk("single_busy", {31'd0, busy5}, 32'd0);
    chk("single_drained", exp_q5.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {8'h5A, 8'(i), 8'hC3, 8'(~i)};
    regs[0] = 32'h0000_0004;
    regs[1] = 32'h1234_5678;
    regs[5] = 32'hDEAD_BEEF;

    #3;
    chk("rst_addr", {27'd0, regAddr}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    #19 rst_n = 1'b1;

    // Full dump, ready held high.
    run_dump(0, 193);
    // Backpressure on byte 34 of r1: exactly three extra cycles.
    run_dump(2, 196);
    // Single register instance, twice.
    run_single();
    run_single();
    // start held during the whole dump.
    run_dump(3, 193);

    // Asynchronous reset in the middle of SEND.
    push_sweep();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (24) @(posedge clk);
    #3;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_addr", {27'd0, regAddr}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_dump(0, 193);

    // Random ready over a full dump.
    run_dump(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sm_debug_dumper.md
Name: sm_debug_dumper

Overview:
- Reader side of the CPU debug register port: drives regAddr, samples the CPU's combinational regData, and serialises register contents as a byte stream with valid/ready handshake (feeds a UART transmitter or a host FIFO).
- On a start pulse it sweeps registers FIRST_REG..LAST_REG. Address 0 returns the PC, per the debug port definition.
- Each register is emitted as 5 bytes: a tag byte followed by 4 data bytes, MSB first.

Parameters:
- FIRST_REG, 0, first debug address dumped (0..31).
- LAST_REG, 31, last debug address dumped (0..31). Must satisfy FIRST_REG <= LAST_REG; any other configuration is illegal and the bench does not exercise it.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- regAddr  out  5  debug register address to the CPU
- regData  in  32  debug register data from the CPU (combinational from regAddr)
- out_data  out  8  stream byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the byte when out_valid & out_ready at a rising edge
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of state): state=IDLE, regAddr=0, out_data=0, out_valid=0, busy=0, done=0, byte counter=0, shift register=0. All outputs are registered.
- States: IDLE, ADDR, SEND.
- IDLE:
  - done=0 except for the pulse cycle.
  - On an edge with start=1: regAddr<=FIRST_REG, busy<=1, state<=ADDR.
- ADDR:
  - regAddr is held stable for one full cycle so regData can settle.
  - At the next edge: shift<={3'b101, regAddr, regData} (40 bits), out_data<={3'b101, regAddr}, out_valid<=1, cnt<=0, state<=SEND.
- SEND:
  - While out_valid & !out_ready, out_data and out_valid hold stable.
  - On accept with cnt<4: out_data<=next byte (regData[31:24], [23:16], [15:8], [7:0] in order), cnt<=cnt+1.
  - On accept with cnt==4 and regAddr!=LAST_REG: out_valid<=0, regAddr<=regAddr+1, state<=ADDR. This gives one bubble cycle per register.
  - On accept with cnt==4 and regAddr==LAST_REG: out_valid<=0, busy<=0, done<=1 for one cycle, regAddr<=0, state<=IDLE.
- The compare is done before the increment, so no 5-bit wrap occurs when LAST_REG=31.
- Timing with out_ready held at 1:
  - Start edge to first out_valid = 2 edges.
  - 6 cycles per register.
  - Full 0..31 dump: done is high in the cycle after edge 193, counting the start edge as edge 1.
- start while busy: ignored, with no effect on the sweep in progress.
- Snapshot semantics: each register is sampled independently at its own ADDR cycle. The CPU keeps running, so the dump is not atomic across registers; the tag byte identifies the source of each record.
- out_ready may toggle arbitrarily, and may be 1 while out_valid=0 without effect.
- Tag encoding: address 0 gives 8'hA0, address 31 gives 8'hBF.

Test Plan:
1. Full dump, out_ready=1: r1=32'h12345678, PC=32'h00000004 at sample time, pulse start -> 160 bytes. The stream begins A0 00 00 00 04 A1 12 34 56 78 and the last record's tag is BF. done pulses exactly once, in the cycle after edge 193 (start edge = edge 1). busy is high from the edge after start until done.
2. Backpressure: out_ready=0 for 3 cycles while byte 8'h34 of r1 is presented -> out_data stays 8'h34 and out_valid stays 1 for all 3 cycles. Stream order and content are unchanged, and total time grows by exactly 3 cycles.
3. Single register, FIRST_REG=LAST_REG=5, r5=32'hDEADBEEF -> bytes A5 DE AD BE EF, then done. regAddr returns to 0 and a second start repeats the identical output.
4. start reasserted on every cycle during a dump -> exactly one sweep and one done pulse; no restart.
5. rst_n asserted mid-SEND, asynchronously between edges -> out_valid, busy and regAddr go to 0 immediately. After release, a new start yields a complete, correct dump beginning with tag A0.
6. Random out_ready with 50% duty over a full dump -> the byte sequence matches the reference model, and no byte is duplicated or dropped.
